// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive truth-table response checker (optional TT_CONFLICT_DET_EN)
module truth_table_checker #(
    parameter int                 N_IN     = 4,
    parameter logic [2**N_IN-1:0] EXPECTED = 16'hE8E8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 vec_valid,
    input  logic [N_IN-1:0]      vec,
    input  logic                 f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 first_err_vld,
    output logic [2**N_IN-1:0]   table_out,
    output logic [2**N_IN-1:0]   cov
`ifdef TT_CONFLICT_DET_EN
    ,
    output logic                 conflict
`endif
);

    localparam int              D        = 2**N_IN;
    localparam logic [D-1:0]    ONE_D    = {{(D-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   ONE_CNT  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] idx;
    logic [D-1:0]    vec_mask;
    logic [D-1:0]    cov_next;
    logic [N_IN:0]   err_next;
    logic            mismatch;
    logic            last_idx;
    logic            clear_run;
    logic            force_fail;

    assign busy = (state == S_COLLECT) || (state == S_COMPARE);
    assign done = (state == S_DONE);

`ifdef TT_CONFLICT_DET_EN
    assign force_fail = conflict;
`else
    assign force_fail = 1'b0;
`endif

    // Next-state logic plus the coverage/compare helpers shared with the datapath
    always_comb begin
        state_next = state;
        vec_mask   = vec_valid ? (ONE_D << vec) : '0;
        cov_next   = cov | vec_mask;
        mismatch   = table_out[idx] != EXPECTED[idx];
        err_next   = mismatch ? (err_cnt + ONE_CNT) : err_cnt;
        last_idx   = (idx == LAST_IDX);
        clear_run  = start && ((state == S_IDLE) || (state == S_DONE));
        case (state)
            S_IDLE:    if (start) state_next = S_COLLECT;
            S_COLLECT: if (&cov_next) state_next = S_COMPARE;
            S_COMPARE: if (last_idx) state_next = S_DONE;
            S_DONE:    if (start) state_next = S_COLLECT;
            default:   state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Table capture, coverage and the one-index-per-cycle comparison walk
    always_ff @(posedge clk) begin
        if (rst || clear_run) begin
            table_out     <= '0;
            cov           <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            pass          <= 1'b0;
            idx           <= '0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (vec_valid) begin
                        table_out[vec] <= f;
                        cov            <= cov_next;
                    end
                end
                S_COMPARE: begin
                    idx     <= idx + 1'b1;
                    err_cnt <= err_next;
                    if (mismatch && !first_err_vld) begin
                        first_err_idx <= idx;
                        first_err_vld <= 1'b1;
                    end
                    // err_next folds in the final index so pass is correct on DONE entry
                    if (last_idx) begin
                        pass <= (err_next == '0) && !force_fail;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TT_CONFLICT_DET_EN
    // Sticky flag for a repeated vector whose f disagrees with the stored entry
    always_ff @(posedge clk) begin
        if (rst || clear_run) begin
            conflict <= 1'b0;
        end else if ((state == S_COLLECT) && vec_valid && cov[vec] && (f != table_out[vec])) begin
            conflict <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker
module tb_truth_table_checker;

    localparam logic [15:0] EXP_TT = 16'hE8E8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        vec_valid = 1'b0;
    logic [3:0]  vec = '0;
    logic        f = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic        first_err_vld;
    logic [15:0] table_out;
    logic [15:0] cov;
`ifdef TT_CONFLICT_DET_EN
    logic        conflict;
`endif

    truth_table_checker #(.N_IN(4), .EXPECTED(16'hE8E8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec_valid     (vec_valid),
        .vec           (vec),
        .f             (f),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld),
        .table_out     (table_out),
        .cov           (cov)
`ifdef TT_CONFLICT_DET_EN
        ,
        .conflict      (conflict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass;
        logic [4:0]  err;
        logic [3:0]  fidx;
        logic        fvld;
        logic [15:0] tbl;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising done pops one expected result
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_latency", cyc, e.cyc);
                check("pass", {31'd0, pass}, {31'd0, e.pass});
                check("err_cnt", {27'd0, err_cnt}, {27'd0, e.err});
                check("first_err_idx", {28'd0, first_err_idx}, {28'd0, e.fidx});
                check("first_err_vld", {31'd0, first_err_vld}, {31'd0, e.fvld});
                check("table_out", {16'd0, table_out}, {16'd0, e.tbl});
                check("cov", {16'd0, cov}, 32'h0000_FFFF);
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
        prev_done <= done;
    end

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send(input logic [3:0] v, input logic b);
        @(negedge clk);
        vec_valid = 1'b1; vec = v; f = b;
        last_cyc = cyc;
    endtask

    task automatic idle();
        @(negedge clk); vec_valid = 1'b0;
    endtask

    task automatic expect_run(input logic p, input logic [4:0] e, input logic [3:0] fi,
                              input logic fv, input logic [15:0] t);
        exp_t x;
        x.pass = p; x.err = e; x.fidx = fi; x.fvld = fv; x.tbl = t; x.cyc = last_cyc + 17;
        sb.push_back(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk); n++;
        end
        check(name, sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] tt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_cov", {16'd0, cov}, 0);
        check("rst_table", {16'd0, table_out}, 0);
        check("rst_err", {27'd0, err_cnt}, 0);

        // 1: ascending, all correct
        start_pulse();
        for (int v = 0; v < 16; v++) send(v[3:0], EXP_TT[v]);
        expect_run(1'b1, 5'd0, 4'd0, 1'b0, 16'hE8E8);
        idle();
`ifdef TT_CONFLICT_DET_EN
        check("conflict_clean", {31'd0, conflict}, 0);
`endif
        drain("timeout_s1");

        // 2: vectors 5 and 9 wrong; start from DONE clears results
        start_pulse();
        check("s2_busy", {31'd0, busy}, 1);
        check("s2_cleared_cov", {16'd0, cov}, 0);
        check("s2_cleared_pass", {31'd0, pass}, 0);
        for (int v = 0; v < 16; v++) send(v[3:0], EXP_TT[v] ^ ((v == 5) || (v == 9)));
        expect_run(1'b0, 5'd2, 4'd5, 1'b1, 16'hEAC8);
        idle();
        drain("timeout_s2");

        // 3: descending with idle gaps
        start_pulse();
        for (int v = 15; v >= 1; v--) begin
            send(v[3:0], EXP_TT[v]);
            idle();
        end
        check("s3_busy_partial", {31'd0, busy}, 1);
        check("s3_done_partial", {31'd0, done}, 0);
        check("s3_cov_partial", {16'd0, cov}, 32'h0000_FFFE);
        send(4'd0, EXP_TT[0]);
        expect_run(1'b1, 5'd0, 4'd0, 1'b0, 16'hE8E8);
        idle();
        drain("timeout_s3");

        // 4: vector 3 repeated with differing f, last value wins
        start_pulse();
        send(4'd3, 1'b1);
        send(4'd3, 1'b0);
        for (int v = 0; v < 16; v++) if (v != 3) send(v[3:0], EXP_TT[v]);
        expect_run(1'b0, 5'd1, 4'd3, 1'b1, 16'hE8E0);
        idle();
        drain("timeout_s4");
`ifdef TT_CONFLICT_DET_EN
        check("conflict_set", {31'd0, conflict}, 1);
`endif

        // 5: reset mid-COLLECT, then rst and start together
        start_pulse();
        for (int v = 0; v < 8; v++) send(v[3:0], EXP_TT[v]);
        idle();
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("s5_busy", {31'd0, busy}, 0);
        check("s5_cov", {16'd0, cov}, 0);
        check("s5_table", {16'd0, table_out}, 0);
        check("s5_pass", {31'd0, pass}, 0);
        rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_beats_start", {31'd0, busy}, 0);

        // 6: vec_valid in IDLE ignored; start during COMPARE ignored; DONE holds
        send(4'd2, 1'b1);
        send(4'd7, 1'b0);
        idle();
        check("s6_idle_cov", {16'd0, cov}, 0);
        check("s6_idle_table", {16'd0, table_out}, 0);
        start_pulse();
        for (int v = 0; v < 16; v++) send(v[3:0], EXP_TT[v]);
        expect_run(1'b1, 5'd0, 4'd0, 1'b0, 16'hE8E8);
        idle();
        repeat (4) @(negedge clk);
        start_pulse();
        check("s6_busy_compare", {31'd0, busy}, 1);
        drain("timeout_s6");
        repeat (4) @(negedge clk);
        check("s6_hold_done", {31'd0, done}, 1);
        check("s6_hold_pass", {31'd0, pass}, 1);
        tt = table_out;
        check("s6_hold_table", {16'd0, tt}, 32'h0000_E8E8);
        start_pulse();
        check("s6_restart_busy", {31'd0, busy}, 1);
        check("s6_restart_done", {31'd0, done}, 0);
        check("s6_restart_cov", {16'd0, cov}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1);
    end

endmodule
